// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the Mini-SRC PC / instruction-fetch sequencer.
package pc_ctrl_pkg;

    // State encoding is visible on state_dbg, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_T0     = 3'd1,
        ST_WAIT   = 3'd2,
        ST_T2     = 3'd3,
        ST_EXEC   = 3'd4,
        ST_BRANCH = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    localparam int TIMEOUT_DEFAULT = 16;
    localparam int CNT_W_DEFAULT   = 32;

    // Width of the wait counter; never below one bit.
    function automatic int timer_width(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts WAIT cycles without mem_ready; terminal marks the last allowed one.
module fetch_wait_timer
    import pc_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int W = timer_width(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    // Clear has priority so every WAIT entry starts counting from zero.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Moore FSM sequencing PC, MAR, MDR and IR through fetch, execute hand-off,
// branch capture, halt and fetch-timeout fault.
module pc_fetch_sequencer
    import pc_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic             mem_ready,
    input  logic             exec_done,
    input  logic             branch_req,
    input  logic             con_ff,
    input  logic             halt_req,
    output logic             pc_out,
    output logic             mar_in,
    output logic             pc_increment,
    output logic             pc_enable,
    output logic             mem_read,
    output logic             mdr_in,
    output logic             ir_in,
    output logic             exec_start,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] instr_count,
    output logic [2:0]       state_dbg
);

    state_t state;
    logic   wait_clear;
    logic   wait_enable;
    logic   wait_last;

    // T0 always precedes WAIT, so clearing during T0 zeroes the count on entry.
    assign wait_clear  = clr | (state == ST_T0);
    assign wait_enable = (state == ST_WAIT) & ~mem_ready;

    fetch_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .clear    (wait_clear),
        .enable   (wait_enable),
        .terminal (wait_last)
    );

    // State register with next-state selection; inputs are only looked at
    // in the states that qualify them.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, matching the hardware.
        if (clr) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (run) state <= ST_T0;
                ST_T0:     state <= ST_WAIT;
                ST_WAIT: begin
                    if (mem_ready)      state <= ST_T2;
                    else if (wait_last) state <= ST_ERR;
                end
                ST_T2:     state <= ST_EXEC;
                ST_EXEC: begin
                    if (exec_done) begin
                        if (halt_req)                  state <= ST_HALT;
                        else if (branch_req && con_ff) state <= ST_BRANCH;
                        else if (run)                  state <= ST_T0;
                        else                           state <= ST_IDLE;
                    end
                end
                ST_BRANCH: state <= run ? ST_T0 : ST_IDLE;
                ST_HALT:   state <= ST_HALT;
                ST_ERR:    state <= ST_ERR;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Retired-instruction counter: one step per T2, i.e. per exec_start.
    always_ff @(posedge clk) begin
        if (clr) begin
            instr_count <= '0;
        end else if (state == ST_T2) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

    // Strobe decode from the registered state only.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        pc_out       = 1'b0;
        mar_in       = 1'b0;
        pc_increment = 1'b0;
        pc_enable    = 1'b0;
        mem_read     = 1'b0;
        mdr_in       = 1'b0;
        ir_in        = 1'b0;
        exec_start   = 1'b0;
        halted       = 1'b0;
        mem_err      = 1'b0;
        case (state)
            ST_T0: begin
                pc_out       = 1'b1;
                mar_in       = 1'b1;
                pc_increment = 1'b1;
            end
            ST_WAIT: begin
                mem_read = 1'b1;
                mdr_in   = 1'b1;
            end
            ST_T2: begin
                ir_in      = 1'b1;
                exec_start = 1'b1;
            end
            ST_BRANCH: pc_enable = 1'b1;
            ST_HALT:   halted    = 1'b1;
            ST_ERR: begin
                halted  = 1'b1;
                mem_err = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer (TIMEOUT=4, CNT_W=4).
module tb_pc_fetch_sequencer;

    localparam int CW = 4;

    // State codes as published on state_dbg.
    localparam logic [2:0] S_I = 3'd0, S_T0 = 3'd1, S_W = 3'd2, S_T2 = 3'd3,
                           S_E = 3'd4, S_B = 3'd5, S_H = 3'd6, S_ER = 3'd7;

    // Input masks: {clr, run, mem_ready, exec_done, branch_req, con_ff, halt_req}
    localparam logic [6:0] NONE = 7'b0000000, CLR = 7'b1000000, RUN = 7'b0100000,
                           RDY = 7'b0010000, DONE = 7'b0001000, BR = 7'b0000100,
                           CON = 7'b0000010, HLT = 7'b0000001;

    typedef struct packed {
        logic [6:0] in;
        logic [2:0] st;   // state expected during the cycle these inputs are held
    } vec_t;

    typedef struct packed {
        logic [2:0]    st;
        logic [9:0]    strobes;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk, clr, run, mem_ready, exec_done, branch_req, con_ff, halt_req;
    logic pc_out, mar_in, pc_increment, pc_enable, mem_read, mdr_in, ir_in;
    logic exec_start, halted, mem_err;
    logic [CW-1:0] instr_count;
    logic [2:0]    state_dbg;

    pc_fetch_sequencer #(.TIMEOUT(4), .CNT_W(CW)) dut (
        .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready),
        .exec_done(exec_done), .branch_req(branch_req), .con_ff(con_ff),
        .halt_req(halt_req), .pc_out(pc_out), .mar_in(mar_in),
        .pc_increment(pc_increment), .pc_enable(pc_enable), .mem_read(mem_read),
        .mdr_in(mdr_in), .ir_in(ir_in), .exec_start(exec_start),
        .halted(halted), .mem_err(mem_err), .instr_count(instr_count),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [CW-1:0] model_cnt = '0;
    exp_t sb[$];
    vec_t vecs[$];

    // {pc_out, mar_in, pc_increment, pc_enable, mem_read, mdr_in, ir_in,
    //  exec_start, halted, mem_err} for each state.
    function automatic logic [9:0] exp_strobes(input logic [2:0] st);
        case (st)
            S_T0:    return 10'b1110000000;
            S_W:     return 10'b0000110000;
            S_T2:    return 10'b0000001100;
            S_B:     return 10'b0001000000;
            S_H:     return 10'b0000000010;
            S_ER:    return 10'b0000000011;
            default: return 10'b0000000000;
        endcase
    endfunction

    function automatic vec_t mk(input logic [6:0] in, input logic [2:0] st);
        vec_t v;
        v.in = in;
        v.st = st;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s vec %0d: got %0h, required %0h", name, vectors, act, req);
        end
    endtask

    // One cycle: drive inputs after the edge, queue the expectation, compare
    // on the falling edge.
    task automatic step(input vec_t v);
        exp_t e, got;
        @(posedge clk);
        #1;
        {clr, run, mem_ready, exec_done, branch_req, con_ff, halt_req} = v.in;
        e.st      = v.st;
        e.strobes = exp_strobes(v.st);
        e.cnt     = model_cnt;
        sb.push_back(e);
        if (v.in[6])          model_cnt = '0;
        else if (v.st == S_T2) model_cnt = model_cnt + 1'b1;
        @(negedge clk);
        got = sb.pop_front();
        check("state_dbg", 32'(state_dbg), 32'(got.st));
        check("strobes", 32'({pc_out, mar_in, pc_increment, pc_enable, mem_read,
                              mdr_in, ir_in, exec_start, halted, mem_err}),
              32'(got.strobes));
        check("instr_count", 32'(instr_count), 32'(got.cnt));
        vectors++;
    endtask

    initial begin
        {clr, run, mem_ready, exec_done, branch_req, con_ff, halt_req} = CLR;

        // Nominal fetch, exec_done two cycles into EXEC.
        vecs.push_back(mk(RUN, S_I));
        vecs.push_back(mk(RUN, S_T0));
        vecs.push_back(mk(RUN | RDY, S_W));
        vecs.push_back(mk(RUN, S_T2));
        vecs.push_back(mk(RUN, S_E));
        vecs.push_back(mk(RUN | DONE, S_E));
        // Taken branch.
        vecs.push_back(mk(RUN, S_T0));
        vecs.push_back(mk(RUN | RDY, S_W));
        vecs.push_back(mk(RUN, S_T2));
        vecs.push_back(mk(RUN | DONE | BR | CON, S_E));
        vecs.push_back(mk(RUN, S_B));
        // Not-taken branch; mem_ready in T0 is ignored.
        vecs.push_back(mk(RUN | RDY, S_T0));
        vecs.push_back(mk(RUN | RDY, S_W));
        vecs.push_back(mk(RUN, S_T2));
        vecs.push_back(mk(RUN | DONE | BR, S_E));
        // run dropped mid-fetch, three WAIT cycles, EXEC exit to IDLE.
        vecs.push_back(mk(NONE, S_T0));
        vecs.push_back(mk(NONE, S_W));
        vecs.push_back(mk(NONE, S_W));
        vecs.push_back(mk(RDY, S_W));
        vecs.push_back(mk(NONE, S_T2));
        vecs.push_back(mk(BR | CON | HLT, S_E));
        vecs.push_back(mk(DONE, S_E));
        vecs.push_back(mk(DONE | HLT, S_I));
        // Taken branch with run low at BRANCH exit.
        vecs.push_back(mk(RUN, S_I));
        vecs.push_back(mk(RUN, S_T0));
        vecs.push_back(mk(RUN | RDY, S_W));
        vecs.push_back(mk(RUN, S_T2));
        vecs.push_back(mk(RUN | DONE | BR | CON, S_E));
        vecs.push_back(mk(NONE, S_B));
        vecs.push_back(mk(NONE, S_I));

        foreach (vecs[i]) step(vecs[i]);

        // Timeout: exactly 4 WAIT cycles, then sticky ERR until clr.
        step(mk(RUN, S_I));
        step(mk(RUN, S_T0));
        for (int i = 0; i < 4; i++) step(mk((i % 2 == 1) ? RUN : NONE, S_W));
        step(mk(RUN, S_ER));
        step(mk(NONE, S_ER));
        step(mk(RDY | DONE | HLT, S_ER));
        step(mk(CLR | RUN, S_ER));
        step(mk(NONE, S_I));

        // Priority: halt wins over a taken branch; HALT held until clr.
        step(mk(RUN, S_I));
        step(mk(RUN, S_T0));
        step(mk(RUN | RDY, S_W));
        step(mk(RUN, S_T2));
        step(mk(RUN | DONE | HLT | BR | CON, S_E));
        step(mk(RUN, S_H));
        step(mk(RUN | DONE, S_H));
        step(mk(CLR, S_H));
        step(mk(NONE, S_I));

        // Reset on the second WAIT cycle; later mem_ready ignored.
        step(mk(RUN, S_I));
        step(mk(NONE, S_T0));
        step(mk(NONE, S_W));
        step(mk(CLR, S_W));
        step(mk(RDY, S_I));
        step(mk(NONE, S_I));

        // Back-to-back fetches until instr_count wraps.
        step(mk(RUN, S_I));
        for (int i = 0; i < 17; i++) begin
            step(mk(RUN, S_T0));
            step(mk(RUN | RDY, S_W));
            step(mk(RUN, S_T2));
            step(mk(RUN | DONE, S_E));
        end
        step(mk(NONE, S_T0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
